register_file_32: RTL and testbench
===================================

REGISTER_FILE_32 -- requirements
Module: register_file_32

Interface
REQ-001 Parameter N, default 8: width of every register and data port.
REQ-002 Parameter BYPASS, default 0: 1 enables write-to-read forwarding; 0 disables it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; 0 clears all state immediately.
REQ-005 RegWrite  input  1  write enable from the control unit.
REQ-006 Write_Reg  input  5  destination register index (rd).
REQ-007 Write_Data  input  N  writeback value from the regfile input mux.
REQ-008 Read_Reg1  input  5  source index rs1.
REQ-009 Read_Reg2  input  5  source index rs2.
REQ-010 Dbg_Addr  input  5  debug/bench read index.
REQ-011 Read_Data1  output  N  value of rs1.
REQ-012 Read_Data2  output  N  value of rs2.
REQ-013 Dbg_Data  output  N  value of register Dbg_Addr.
REQ-014 Write_Count  output  16  count of committed writes since reset.

Function
REQ-015 Storage SHALL be 31 N-bit registers x1..x31; x0 SHALL be a constant 0 with no storage.
REQ-016 A write SHALL commit on the rising clk edge when rst=1, RegWrite=1 and Write_Reg!=0: x[Write_Reg] <= Write_Data.
REQ-017 Writes to x0 and writes with RegWrite=0 SHALL change no register and SHALL not increment Write_Count.
REQ-018 Write_Count SHALL increment by 1 on each committed write and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-019 Read_Data1, Read_Data2 and Dbg_Data SHALL be combinational (zero-cycle latency) from their index inputs.
REQ-020 Reading index 0 on any port SHALL return 0 regardless of prior writes to x0.
REQ-021 With BYPASS=0, a read of the register being written in the same cycle SHALL return the old value until the edge, and the new value after it.
REQ-022 With BYPASS=1, when RegWrite=1, Write_Reg!=0 and a read index equals Write_Reg, that port SHALL return Write_Data in the same cycle; Dbg_Data SHALL never be bypassed.
REQ-023 BYPASS SHALL be 0 in the single-cycle core to avoid a combinational loop through the ALU and writeback mux.
REQ-024 Both read ports may address the same register simultaneously and SHALL return identical values.
REQ-025 Out-of-range behaviour SHALL NOT exist: all 32 index values are legal.

Reset
REQ-026 While rst=0, all registers x1..x31 SHALL read 0 and Write_Count SHALL be 0, independent of clk.
REQ-027 Reset assertion mid-cycle SHALL clear state immediately, without waiting for a clk edge; a write pending in that cycle SHALL be dropped.
REQ-028 After rst deasserts, the first write SHALL commit on the first rising clk edge with rst=1.
REQ-029 Read outputs SHALL follow REQ-019..REQ-022 during reset: read 0 for stored registers; with BYPASS=1, forwarding SHALL be suppressed while rst=0.

Verification
REQ-030 rst=0 then 1; read all 32 indices via Dbg_Addr -> every Dbg_Data=0, Write_Count=0.
REQ-031 Write x5=8'hA5 then x31=8'h3C; Read_Reg1=5, Read_Reg2=31 -> 8'hA5 / 8'h3C, Write_Count=2.
REQ-032 RegWrite=1, Write_Reg=0, Write_Data=8'hFF -> Read_Data1 at index 0 = 0, Write_Count unchanged.
REQ-033 BYPASS=0: x7=8'h11, then write x7=8'h22 while Read_Reg1=7 -> 8'h11 before the edge, 8'h22 after. BYPASS=1: 8'h22 before the edge.
REQ-034 Preload Write_Count to 16'hFFFF by 65535 writes, write once more -> Write_Count=16'h0000.
REQ-035 Write x3=8'h77, assert rst between clk edges -> Read_Data1(3)=0 immediately; a write in that cycle is not committed.

Source files
------------

// File: rtl/register_file_32_if.sv
// register_file_32_if
// Bundles the register-file access signals so the core and a bench/controller
// can connect through one port.
//   master : drives the write port (RegWrite, Write_Reg, Write_Data) and the
//            read indices (Read_Reg1, Read_Reg2, Dbg_Addr); observes the data.
//   slave  : the register file itself; returns Read_Data1, Read_Data2,
//            Dbg_Data and Write_Count.
interface register_file_32_if #(
  parameter int N = 8
);
  logic         RegWrite;
  logic [4:0]   Write_Reg;
  logic [N-1:0] Write_Data;
  logic [4:0]   Read_Reg1;
  logic [4:0]   Read_Reg2;
  logic [4:0]   Dbg_Addr;
  logic [N-1:0] Read_Data1;
  logic [N-1:0] Read_Data2;
  logic [N-1:0] Dbg_Data;
  logic [15:0]  Write_Count;

  modport master (
    output RegWrite, Write_Reg, Write_Data, Read_Reg1, Read_Reg2, Dbg_Addr,
    input  Read_Data1, Read_Data2, Dbg_Data, Write_Count
  );

  modport slave (
    input  RegWrite, Write_Reg, Write_Data, Read_Reg1, Read_Reg2, Dbg_Addr,
    output Read_Data1, Read_Data2, Dbg_Data, Write_Count
  );
endinterface

// File: rtl/register_file_32.sv
// register_file_32
// 32-entry register file: x1..x31 are N-bit registers, x0 is hard-wired zero
// and has no storage. Two combinational read ports plus a debug read port,
// one write port, and a 16-bit count of committed writes.
// Ports:
//   clk  : rising-edge clock for all state
//   rst  : asynchronous active-low reset, clears registers and the counter
//   bus  : register_file_32_if.slave (write port, read indices, read data,
//          Write_Count)
// Parameters:
//   N      : data width
//   BYPASS : 1 forwards Write_Data to Read_Data1/2 when the index matches the
//            register being written this cycle; keep 0 in a single-cycle core
//            so no loop forms through ALU and writeback mux.
module register_file_32 #(
  parameter int N      = 8,
  parameter bit BYPASS = 1'b0
) (
  input logic               clk,
  input logic               rst,
  register_file_32_if.slave bus
);

  logic [N-1:0] regs_r [1:31];
  logic [15:0]  write_count_r;
  logic         commit_s;
  logic         fwd_en_s;
  logic [N-1:0] rd1_s;
  logic [N-1:0] rd2_s;
  logic [N-1:0] dbg_s;

  // A write only counts when it targets a real register.
  assign commit_s = bus.RegWrite && (bus.Write_Reg != 5'd0);

  // Forwarding is held off during reset so reads report the cleared state.
  assign fwd_en_s = BYPASS && rst && commit_s;

  // Register array: async clear, one register updated per committed write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (commit_s && (bus.Write_Reg == 5'(i))) begin
          regs_r[i] <= bus.Write_Data;
        end
      end
    end
  end

  // Committed-write counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_count_r <= 16'd0;
    end else if (commit_s) begin
      write_count_r <= write_count_r + 16'd1;
    end
  end

  // Combinational read muxes; index 0 falls through to the zero default.
  always_comb begin
    rd1_s = '0;
    rd2_s = '0;
    dbg_s = '0;
    for (int i = 1; i < 32; i++) begin
      if (bus.Read_Reg1 == 5'(i)) begin
        rd1_s = regs_r[i];
      end else begin
        rd1_s = rd1_s;
      end
      if (bus.Read_Reg2 == 5'(i)) begin
        rd2_s = regs_r[i];
      end else begin
        rd2_s = rd2_s;
      end
      if (bus.Dbg_Addr == 5'(i)) begin
        dbg_s = regs_r[i];
      end else begin
        dbg_s = dbg_s;
      end
    end
  end

  // Output drive with optional same-cycle forwarding on the two core ports;
  // the debug port always shows stored state.
  always_comb begin
    bus.Read_Data1  = rd1_s;
    bus.Read_Data2  = rd2_s;
    bus.Dbg_Data    = dbg_s;
    bus.Write_Count = write_count_r;
    if (fwd_en_s && (bus.Read_Reg1 == bus.Write_Reg)) begin
      bus.Read_Data1 = bus.Write_Data;
    end else begin
      bus.Read_Data1 = rd1_s;
    end
    if (fwd_en_s && (bus.Read_Reg2 == bus.Write_Reg)) begin
      bus.Read_Data2 = bus.Write_Data;
    end else begin
      bus.Read_Data2 = rd2_s;
    end
  end

endmodule

// File: tb/tb_register_file_32.sv
// tb_register_file_32
// Self-checking bench for register_file_32. Two instances share identical
// stimulus: dut0 with forwarding off, dut1 with forwarding on.
module tb_register_file_32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  register_file_32_if #(.N(8)) bus0 ();
  register_file_32_if #(.N(8)) bus1 ();

  register_file_32 #(.N(8), .BYPASS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  register_file_32 #(.N(8), .BYPASS(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] wreg;
    logic [7:0] wdata;
    logic [4:0] rr1;
    logic [4:0] rr2;
    logic [4:0] dbg;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] ed;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [7:0] wdata,
                       input logic [4:0] rr1, input logic [4:0] rr2, input logic [4:0] dbg);
    bus0.RegWrite = we;  bus1.RegWrite = we;
    bus0.Write_Reg = wreg; bus1.Write_Reg = wreg;
    bus0.Write_Data = wdata; bus1.Write_Data = wdata;
    bus0.Read_Reg1 = rr1; bus1.Read_Reg1 = rr1;
    bus0.Read_Reg2 = rr2; bus1.Read_Reg2 = rr2;
    bus0.Dbg_Addr = dbg; bus1.Dbg_Addr = dbg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_we();
    bus0.RegWrite = 1'b0;
    bus1.RegWrite = 1'b0;
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{1'b1, 5'd5,  8'hA5, 5'd5,  5'd0,  5'd5,  8'hA5, 8'h00, 8'hA5, 16'd1};
    vecs[1] = '{1'b1, 5'd31, 8'h3C, 5'd5,  5'd31, 5'd31, 8'hA5, 8'h3C, 8'h3C, 16'd2};
    vecs[2] = '{1'b1, 5'd0,  8'hFF, 5'd0,  5'd5,  5'd0,  8'h00, 8'hA5, 8'h00, 16'd2};
    vecs[3] = '{1'b0, 5'd5,  8'h00, 5'd5,  5'd5,  5'd5,  8'hA5, 8'hA5, 8'hA5, 16'd2};
    vecs[4] = '{1'b1, 5'd1,  8'h80, 5'd1,  5'd31, 5'd1,  8'h80, 8'h3C, 8'h80, 16'd3};
    vecs[5] = '{1'b1, 5'd5,  8'h5A, 5'd5,  5'd1,  5'd5,  8'h5A, 8'h80, 8'h5A, 16'd4};
    vecs[6] = '{1'b1, 5'd16, 8'hFF, 5'd16, 5'd16, 5'd0,  8'hFF, 8'hFF, 8'h00, 16'd5};

    // Reset held: a write attempt across edges must be ignored.
    rst = 1'b0;
    drive(1'b1, 5'd9, 8'hEE, 5'd9, 5'd9, 5'd9);
    #1;
    check("rst_rd1_x9", {8'h00, bus1.Read_Data1}, 16'h0000);
    tick();
    tick();
    check("rst_dbg_x9", {8'h00, bus0.Dbg_Data}, 16'h0000);
    check("rst_cnt",    bus0.Write_Count, 16'h0000);
    check("rst_byp_rd1", {8'h00, bus1.Read_Data1}, 16'h0000);

    // Release reset, then sweep every index on the debug port.
    drive(1'b0, 5'd0, 8'h00, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      bus0.Dbg_Addr = 5'(a);
      bus1.Dbg_Addr = 5'(a);
      #1;
      check($sformatf("sweep_dbg0_%0d", a), {8'h00, bus0.Dbg_Data}, 16'h0000);
      check($sformatf("sweep_dbg1_%0d", a), {8'h00, bus1.Dbg_Data}, 16'h0000);
    end
    check("sweep_cnt", bus0.Write_Count, 16'h0000);

    // Table-driven writes; reads checked after the edge with the write port idle.
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].we, vecs[v].wreg, vecs[v].wdata, vecs[v].rr1, vecs[v].rr2, vecs[v].dbg);
      tick();
      idle_we();
      #1;
      check($sformatf("vec%0d_rd1_d0", v), {8'h00, bus0.Read_Data1}, {8'h00, vecs[v].e1});
      check($sformatf("vec%0d_rd2_d0", v), {8'h00, bus0.Read_Data2}, {8'h00, vecs[v].e2});
      check($sformatf("vec%0d_dbg_d0", v), {8'h00, bus0.Dbg_Data},   {8'h00, vecs[v].ed});
      check($sformatf("vec%0d_cnt_d0", v), bus0.Write_Count,          vecs[v].ecnt);
      check($sformatf("vec%0d_rd1_d1", v), {8'h00, bus1.Read_Data1}, {8'h00, vecs[v].e1});
      check($sformatf("vec%0d_rd2_d1", v), {8'h00, bus1.Read_Data2}, {8'h00, vecs[v].e2});
      check($sformatf("vec%0d_cnt_d1", v), bus1.Write_Count,          vecs[v].ecnt);
    end

    // Read-during-write: old value without forwarding, new value with it.
    drive(1'b1, 5'd7, 8'h11, 5'd7, 5'd7, 5'd7);
    tick();
    drive(1'b1, 5'd7, 8'h22, 5'd7, 5'd0, 5'd7);
    #1;
    check("rdw_pre_d0",     {8'h00, bus0.Read_Data1}, 16'h0011);
    check("rdw_pre_d1",     {8'h00, bus1.Read_Data1}, 16'h0022);
    check("rdw_pre_dbg_d1", {8'h00, bus1.Dbg_Data},   16'h0011);
    check("rdw_pre_rd2_d1", {8'h00, bus1.Read_Data2}, 16'h0000);
    tick();
    idle_we();
    #1;
    check("rdw_post_d0", {8'h00, bus0.Read_Data1}, 16'h0022);
    check("rdw_post_d1", {8'h00, bus1.Read_Data1}, 16'h0022);
    check("rdw_cnt",     bus0.Write_Count, 16'd7);

    // Forwarding must not expose a write to x0.
    drive(1'b1, 5'd0, 8'hFF, 5'd0, 5'd0, 5'd0);
    #1;
    check("x0_nofwd_d1", {8'h00, bus1.Read_Data1}, 16'h0000);
    tick();
    idle_we();
    #1;
    check("x0_cnt", bus1.Write_Count, 16'd7);

    // Mid-cycle reset: clears immediately and drops the pending write.
    drive(1'b1, 5'd3, 8'h77, 5'd3, 5'd3, 5'd3);
    tick();
    idle_we();
    #1;
    check("x3_written", {8'h00, bus0.Read_Data1}, 16'h0077);
    check("x3_cnt",     bus0.Write_Count, 16'd8);
    drive(1'b1, 5'd3, 8'h99, 5'd3, 5'd31, 5'd3);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_rd1_d0", {8'h00, bus0.Read_Data1}, 16'h0000);
    check("midrst_rd1_d1", {8'h00, bus1.Read_Data1}, 16'h0000);
    check("midrst_rd2_d0", {8'h00, bus0.Read_Data2}, 16'h0000);
    check("midrst_cnt",    bus0.Write_Count, 16'h0000);
    tick();
    check("midrst_edge_d0", {8'h00, bus0.Read_Data1}, 16'h0000);
    idle_we();
    rst = 1'b1;
    #1;
    check("postrst_rd1_d0", {8'h00, bus0.Read_Data1}, 16'h0000);
    check("postrst_dbg_d1", {8'h00, bus1.Dbg_Data},   16'h0000);
    check("postrst_cnt",    bus0.Write_Count, 16'h0000);

    // First write after reset release commits on the next edge.
    drive(1'b1, 5'd3, 8'h44, 5'd3, 5'd3, 5'd3);
    tick();
    idle_we();
    #1;
    check("first_wr_d0",  {8'h00, bus0.Read_Data1}, 16'h0044);
    check("first_wr_cnt", bus0.Write_Count, 16'd1);

    // Counter wrap: bring it to 16'hFFFF, then one more write wraps to 0.
    drive(1'b1, 5'd2, 8'h00, 5'd2, 5'd3, 5'd2);
    for (int k = 0; k < 65534; k++) begin
      bus0.Write_Data = 8'(k);
      bus1.Write_Data = 8'(k);
      tick();
    end
    idle_we();
    #1;
    check("wrap_pre_cnt_d0", bus0.Write_Count, 16'hFFFF);
    check("wrap_pre_cnt_d1", bus1.Write_Count, 16'hFFFF);
    check("wrap_x2",         {8'h00, bus0.Read_Data1}, 16'h00FD);
    drive(1'b1, 5'd2, 8'h5C, 5'd2, 5'd3, 5'd2);
    tick();
    idle_we();
    #1;
    check("wrap_cnt_d0", bus0.Write_Count, 16'h0000);
    check("wrap_cnt_d1", bus1.Write_Count, 16'h0000);
    check("wrap_x2_new", {8'h00, bus0.Dbg_Data}, 16'h005C);
    check("wrap_x3_kept", {8'h00, bus0.Read_Data2}, 16'h0044);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
